// File: rtl/seg_scan_ctrl.sv
// Multiplexed four-digit seven-segment scanner with a prescaled tick, a blank gap
// before each digit, and frame-synchronous loading of new display data.
module seg_scan_ctrl #(
    parameter int unsigned PRESCALE_BITS = 10,
    parameter int unsigned SHOW_TICKS    = 3
) (
    input  logic        C,
    input  logic        CLR,
    input  logic        CE,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DP,
    input  logic        LOAD,
    output logic        ACK,
    output logic [7:0]  SEGMENTS,
    output logic [3:0]  DIGIT,
    output logic        FRAME
);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_t;

    localparam logic [3:0] LastCnt = 4'(SHOW_TICKS - 1);

    state_t                   r_state;
    logic [PRESCALE_BITS-1:0] r_pre;
    logic [1:0]               r_digit;
    logic [3:0]               r_cnt;
    logic [15:0]              r_disp_val;
    logic [3:0]               r_disp_dp;
    logic [15:0]              r_pend_val;
    logic [3:0]               r_pend_dp;
    logic                     r_pend;

    logic       w_tick;
    logic       w_show_done;
    logic       w_boundary;
    logic [3:0] w_nib;
    logic [7:0] w_seg;

    assign w_tick      = CE && (&r_pre);
    assign w_show_done = (r_cnt == LastCnt);
    // A frame ends when digit 3 finishes showing; the very first tick also starts one.
    assign w_boundary  = w_tick && ((r_state == StIdle) ||
                         (r_state == StShow && w_show_done && r_digit == 2'd3));
    assign w_nib       = r_disp_val[{r_digit, 2'b00} +: 4];

    always_comb begin
        w_seg = 8'h00;
        unique case (w_nib)
            4'h0: w_seg[6:0] = 7'h3F;
            4'h1: w_seg[6:0] = 7'h06;
            4'h2: w_seg[6:0] = 7'h5B;
            4'h3: w_seg[6:0] = 7'h4F;
            4'h4: w_seg[6:0] = 7'h66;
            4'h5: w_seg[6:0] = 7'h6D;
            4'h6: w_seg[6:0] = 7'h7D;
            4'h7: w_seg[6:0] = 7'h07;
            4'h8: w_seg[6:0] = 7'h7F;
            4'h9: w_seg[6:0] = 7'h6F;
            4'hA: w_seg[6:0] = 7'h77;
            4'hB: w_seg[6:0] = 7'h7C;
            4'hC: w_seg[6:0] = 7'h39;
            4'hD: w_seg[6:0] = 7'h5E;
            4'hE: w_seg[6:0] = 7'h79;
            4'hF: w_seg[6:0] = 7'h71;
            default: w_seg[6:0] = 7'h00;
        endcase
        w_seg[7] = r_disp_dp[r_digit];
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_state    <= StIdle;
            r_pre      <= '0;
            r_digit    <= 2'd0;
            r_cnt      <= 4'd0;
            r_disp_val <= 16'h0000;
            r_disp_dp  <= 4'h0;
            r_pend_val <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_pend     <= 1'b0;
            SEGMENTS   <= 8'h00;
            DIGIT      <= 4'h0;
            ACK        <= 1'b0;
            FRAME      <= 1'b0;
        end else begin
            ACK   <= 1'b0;
            FRAME <= 1'b0;
            if (LOAD) begin
                r_pend_val <= VALUE;
                r_pend_dp  <= DP;
                r_pend     <= 1'b1;
            end
            if (CE) begin
                r_pre <= r_pre + 1'b1;
            end
            if (w_tick) begin
                case (r_state)
                    StIdle: begin
                        r_state  <= StBlank;
                        r_digit  <= 2'd0;
                        r_cnt    <= 4'd0;
                        DIGIT    <= 4'h0;
                        SEGMENTS <= 8'h00;
                    end
                    StBlank: begin
                        r_state  <= StShow;
                        r_cnt    <= 4'd0;
                        DIGIT    <= 4'b0001 << r_digit;
                        SEGMENTS <= w_seg;
                    end
                    StShow: begin
                        if (w_show_done) begin
                            r_state  <= StBlank;
                            r_digit  <= r_digit + 2'd1;
                            r_cnt    <= 4'd0;
                            DIGIT    <= 4'h0;
                            SEGMENTS <= 8'h00;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
            // A LOAD on the boundary clock bypasses pending and lands in this frame.
            if (w_boundary) begin
                FRAME <= 1'b1;
                if (LOAD) begin
                    r_disp_val <= VALUE;
                    r_disp_dp  <= DP;
                    r_pend     <= 1'b0;
                    ACK        <= 1'b1;
                end else if (r_pend) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                    r_pend     <= 1'b0;
                    ACK        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_BITS, default 10: prescaler width; one scan tick every 2^PRESCALE_BITS enabled clocks.
REQ-002 SHALL have parameter SHOW_TICKS, default 3: ticks each digit is driven (legal 1..15).
REQ-003 SHALL have port C  input  1  system clock, rising edge active.
REQ-004 SHALL have port CLR  input  1  reset CLR, asynchronous, active-high.
REQ-005 SHALL have port CE  input  1  clock enable for prescaler and scan sequencing.
REQ-006 SHALL have port VALUE  input  16  four hex nibbles; digit i = VALUE[4i+3:4i].
REQ-007 SHALL have port DP  input  4  decimal point per digit, DP[i] for digit i.
REQ-008 SHALL have port LOAD  input  1  single-cycle request to display VALUE/DP.
REQ-009 SHALL have port ACK  output  1  one-cycle pulse: requested value now displayed.
REQ-010 SHALL have port SEGMENTS  output  8  shared segment bus, bit order Dgfedcba, active-high.
REQ-011 SHALL have port DIGIT  output  4  digit enables, one-hot or zero, active-high.
REQ-012 SHALL have port FRAME  output  1  one-cycle pulse at start of each scan frame.

Function
REQ-013 SHALL increment the prescaler only on clocks with CE=1; tick = CE=1 and prescaler all-ones; prescaler wraps to 0.
REQ-014 SHALL sequence per digit: BLANK (1 tick, DIGIT=0, SEGMENTS=0) then SHOW (SHOW_TICKS ticks, DIGIT one-hot for current digit).
REQ-015 SHALL advance digit index 0->1->2->3->0 on the tick ending SHOW; index wraps 3->0.
REQ-016 SHALL define frame boundary as the tick ending SHOW of digit 3 (and the first tick after reset).
REQ-017 SHALL state states IDLE, BLANK, SHOW; IDLE->BLANK(digit 0) on first tick; BLANK->SHOW on tick; SHOW->BLANK on tick when SHOW_TICKS elapsed.
REQ-018 SHALL drive SEGMENTS in SHOW as hex decode of digit nibble with bit 7 = DP of that digit: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 SHALL register SEGMENTS and DIGIT; both change only on the same clock edge (no single-cycle mismatch).
REQ-020 SHALL capture VALUE/DP into a pending register on any clock with LOAD=1, regardless of CE; later LOAD before boundary overwrites (last wins).
REQ-021 SHALL copy pending into display register only at a frame boundary and pulse ACK for exactly the following clock; no tearing within a frame.
REQ-022 SHALL, if LOAD coincides with the boundary clock, display that VALUE in the new frame and ACK once.
REQ-023 SHALL pulse FRAME on the clock after each frame boundary, coincident with ACK when a load is applied.
REQ-024 SHALL hold all state (prescaler, counters, outputs) while CE=0; LOAD capture still occurs.
REQ-025 SHALL issue no ACK without a preceding LOAD; one ACK per batch of LOADs.

Reset
REQ-026 SHALL on CLR=1 immediately force: state IDLE, prescaler 0, digit index 0, tick count 0, display and pending registers 0, pending flag 0, SEGMENTS=0, DIGIT=0, ACK=0, FRAME=0.
REQ-027 SHALL discard a pending LOAD if CLR asserts mid-frame; no ACK after release.
REQ-028 SHALL resume with first tick after CLR release leading to BLANK of digit 0.

Verification
REQ-029 PRESCALE_BITS=2, SHOW_TICKS=1, CE=1, LOAD VALUE=16'h1234 DP=4'b0001 -> ACK+FRAME at first boundary; digit 0 SHOW: DIGIT=0001 SEGMENTS=8'hE6 ("4"+DP); digit 3 SHOW: DIGIT=1000 SEGMENTS=8'h06.
REQ-030 Same setup, count clocks -> BLANK 4 clocks with DIGIT=0 SEGMENTS=0, SHOW 4 clocks, frame period 32 clocks, FRAME pulse width 1.
REQ-031 LOAD 16'hAAAA then 16'hBEEF mid-frame -> current frame unchanged, next frame shows b,E,E,F (7C,79,79,71), exactly one ACK.
REQ-032 CE toggled 1-of-2 clocks -> all sequencing durations exactly double; LOAD with CE=0 still captured.
REQ-033 CLR asserted during SHOW of digit 2 with pending LOAD -> outputs zero same cycle, no ACK after release, digit 0 shows 3F.
